// File: rtl/multiword_addsub_seq_pkg.sv
// Shared definitions for the sequential multi-word adder/subtractor:
// FSM state encoding, default geometry and the slice-counter width helper.
package mwaddsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int M_DEFAULT = 32;
  localparam int W_DEFAULT = 4;

  // Width needed to count W slices; never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/multiword_addsub_seq_cla.sv
// M-bit carry-lookahead adder-subtractor (M = 8 * 4^k): 4-bit lookahead
// groups chained by group generate/propagate. cout is the raw carry out.
module claAddSub32Pow4
  import mwaddsub_pkg::*;
#(
  parameter int M = M_DEFAULT
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic [M-1:0] sum,
  output logic         cout,
  output logic         v
);

  localparam int NG = M / 4;

  logic [M-1:0] b_eff;
  logic [M-1:0] p;
  logic [M-1:0] g;
  logic [M:0]   c;
  logic         cg;
  logic         grp_g;
  logic         grp_p;

  assign b_eff = b ^ {M{sub}};
  assign p     = a ^ b_eff;
  assign g     = a & b_eff;

  // Only cg (group carry) is carried across loop iterations; in-group
  // carries are expanded directly from it.
  always_comb begin
    c     = '0;
    cg    = cin | sub;
    grp_g = 1'b0;
    grp_p = 1'b0;
    c[0]  = cg;
    for (int j = 0; j < NG; j++) begin
      c[4*j+1] = g[4*j] | (p[4*j] & cg);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & cg);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & cg);
      grp_g = g[4*j+3] | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      grp_p = &p[4*j +: 4];
      cg = grp_g | (grp_p & cg);
      c[4*j+4] = cg;
    end
  end

  assign sum  = p ^ c[M-1:0];
  assign cout = c[M];
  assign v    = c[M] ^ c[M-1];

endmodule

// File: rtl/multiword_addsub_seq.sv
// Sequential N = M*W bit adder/subtractor: one M-bit slice per cycle, LSW
// first. Optional z/n flags enabled by macro MWADDSUB_FLAGS_EN.
//
// state | meaning
// IDLE  | waiting for operands, in_ready = 1, outputs hold last result
// RUN   | slice k fed through the CLA, carry kept raw between slices
// DONE  | result presented, out_valid = 1 until out_ready or abort
module multiword_addsub_seq
  import mwaddsub_pkg::*;
#(
  parameter int M = M_DEFAULT,
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           sub,
  input  logic           cin,
  input  logic [M*W-1:0] x,
  input  logic [M*W-1:0] y,
  output logic           out_valid,
  input  logic           out_ready,
  input  logic           abort,
  output logic [M*W-1:0] out,
  output logic           cout,
  output logic           v,
  output logic           z,
  output logic           n
);

  localparam int N  = M * W;
  localparam int KW = clog2(W);
  localparam logic [KW-1:0] K_LAST = KW'(W - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          c_q, c_d;
  logic          sub_q, sub_d;
  logic [N-1:0]  x_q, x_d;
  logic [N-1:0]  y_q, y_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  out_q, out_d;
  logic          cout_q, cout_d;
  logic          v_q, v_d;

  logic [M-1:0]  slice_sum;
  logic          slice_cout;
  logic          slice_v;

  claAddSub32Pow4 #(.M(M)) u_cla (
    .a    (x_q[M*k_q +: M]),
    .b    (y_q[M*k_q +: M]),
    .sub  (1'b0),
    .cin  (c_q),
    .sum  (slice_sum),
    .cout (slice_cout),
    .v    (slice_v)
  );

`ifdef MWADDSUB_FLAGS_EN
  logic zacc_q, zacc_d;
  logic z_q, z_d;
  logic n_q, n_d;
`endif

  // Partial sums build up in acc; out only changes when a run completes so
  // an abort leaves the previous result visible.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    c_d     = c_q;
    sub_d   = sub_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    out_d   = out_q;
    cout_d  = cout_q;
    v_d     = v_q;
`ifdef MWADDSUB_FLAGS_EN
    zacc_d  = zacc_q;
    z_d     = z_q;
    n_d     = n_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid && !abort) begin
          state_d = S_RUN;
          x_d     = x;
          y_d     = y ^ {N{sub}};
          sub_d   = sub;
          k_d     = '0;
          c_d     = sub | cin;
`ifdef MWADDSUB_FLAGS_EN
          zacc_d  = 1'b1;
`endif
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          k_d     = '0;
        end else begin
          acc_d[M*k_q +: M] = slice_sum;
          c_d = slice_cout;
          k_d = k_q + 1'b1;
`ifdef MWADDSUB_FLAGS_EN
          zacc_d = zacc_q & ~(|slice_sum);
`endif
          if (k_q == K_LAST) begin
            state_d = S_DONE;
            k_d     = '0;
            out_d   = acc_d;
            cout_d  = slice_cout ^ sub_q;
            v_d     = slice_v;
`ifdef MWADDSUB_FLAGS_EN
            z_d     = zacc_q & ~(|slice_sum);
            n_d     = slice_sum[M-1];
`endif
          end
        end
      end
      S_DONE: begin
        if (abort || out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      c_q     <= 1'b0;
      sub_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
      sub_q   <= sub_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
    end
  end

`ifdef MWADDSUB_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zacc_q <= 1'b0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
    end else begin
      zacc_q <= zacc_d;
      z_q    <= z_d;
      n_q    <= n_d;
    end
  end

  assign z = z_q;
  assign n = n_q;
`else
  assign z = 1'b0;
  assign n = 1'b0;
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign cout      = cout_q;
  assign v         = v_q;

endmodule
